// File: rtl/tpll_div_pkg.sv
// Shared constants and helpers for the Tiny-PLL multi-channel clock divider.
package tpll_div_pkg;

  // Smallest legal divisor; anything below is raised to this value.
  localparam int unsigned MIN_DIV = 2;

  // Duty modes.
  localparam logic MODE_HALF  = 1'b0;  // floor(D/2) high cycles
  localparam logic MODE_PULSE = 1'b1;  // single high cycle per period

  // Raise divisors below MIN_DIV to MIN_DIV. Callers truncate to their width.
  function automatic logic [31:0] clamp_div(input logic [31:0] div);
    return (div < 32'(MIN_DIV)) ? 32'(MIN_DIV) : div;
  endfunction

endpackage

// File: rtl/div_channel.sv
// One divider channel: period counter, active divisor/mode, and a single-entry
// shadow register that is applied only at a period boundary, start, or sync.
module div_channel
  import tpll_div_pkg::*;
#(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned RESET_DIV = 2
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             wr,        // qualified config write for this channel
  input  logic [WIDTH-1:0] wr_div,
  input  logic             wr_pulse,
  input  logic             en,
  input  logic             sync,
  output logic             clk_out,
  output logic             tick,
  output logic             active,
  output logic             pending
);

  localparam logic [WIDTH-1:0] ResetDiv = WIDTH'(clamp_div(32'(RESET_DIV)));

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic             mode_q, mode_d;
  logic [WIDTH-1:0] sh_div_q, sh_div_d;
  logic             sh_mode_q, sh_mode_d;
  logic             pend_q, pend_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;
  logic             active_q, active_d;

  logic [WIDTH-1:0] high_len;
  logic [WIDTH-1:0] cnt_inc;
  logic             at_bound;
  logic             apply;

  // Next-state: sync restart, idle start, boundary, or normal counting.
  always_comb begin
    cnt_d     = cnt_q;
    clk_d     = clk_q;
    tick_d    = 1'b0;
    active_d  = active_q;
    apply     = 1'b0;
    high_len  = (mode_q == MODE_PULSE) ? WIDTH'(1) : (div_q >> 1);
    cnt_inc   = cnt_q + WIDTH'(1);
    // >= rather than == keeps the counter bounded even if it ever got ahead.
    at_bound  = (cnt_q >= (div_q - WIDTH'(1)));

    if (active_q && en && sync) begin
      cnt_d    = '0;
      clk_d    = 1'b1;
      tick_d   = 1'b1;
      apply    = pend_q;
    end else if (!active_q) begin
      if (en) begin
        cnt_d    = '0;
        clk_d    = 1'b1;
        tick_d   = 1'b1;
        active_d = 1'b1;
        apply    = pend_q;
      end
    end else if (at_bound) begin
      apply = pend_q;
      cnt_d = '0;
      if (en) begin
        clk_d  = 1'b1;
        tick_d = 1'b1;
      end else begin
        // Stop only here, after a full period, so no runt pulse escapes.
        clk_d    = 1'b0;
        active_d = 1'b0;
      end
    end else begin
      cnt_d = cnt_inc;
      clk_d = (cnt_inc < high_len);
    end
  end

  // Shadow/pending update; a write can only land while nothing is pending, so
  // it never collides with an apply in the same cycle.
  always_comb begin
    div_d     = apply ? sh_div_q  : div_q;
    mode_d    = apply ? sh_mode_q : mode_q;
    sh_div_d  = sh_div_q;
    sh_mode_d = sh_mode_q;
    pend_d    = pend_q;
    if (apply) begin
      pend_d = 1'b0;
    end else if (wr && !pend_q) begin
      sh_div_d  = WIDTH'(clamp_div(32'(wr_div)));
      sh_mode_d = wr_pulse;
      pend_d    = 1'b1;
    end
  end

  // State registers.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      div_q     <= ResetDiv;
      mode_q    <= MODE_HALF;
      sh_div_q  <= '0;
      sh_mode_q <= MODE_HALF;
      pend_q    <= 1'b0;
      clk_q     <= 1'b0;
      tick_q    <= 1'b0;
      active_q  <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      mode_q    <= mode_d;
      sh_div_q  <= sh_div_d;
      sh_mode_q <= sh_mode_d;
      pend_q    <= pend_d;
      clk_q     <= clk_d;
      tick_q    <= tick_d;
      active_q  <= active_d;
    end
  end

  assign clk_out = clk_q;
  assign tick    = tick_q;
  assign active  = active_q;
  assign pending = pend_q;

endmodule

// File: rtl/clk_divider_mc.sv
// Multi-channel programmable integer clock divider. Decodes the config write
// onto one channel and replicates div_channel NCH times.
module clk_divider_mc
  import tpll_div_pkg::*;
#(
  parameter int unsigned NCH       = 4,
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned RESET_DIV = 2,
  parameter int unsigned CH_W      = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [WIDTH-1:0] cfg_div,
  input  logic             cfg_pulse,
  input  logic [NCH-1:0]   ch_en,
  input  logic             sync_in,
  output logic [NCH-1:0]   clk_out,
  output logic [NCH-1:0]   tick,
  output logic [NCH-1:0]   active
);

  localparam int unsigned NSEL = 1 << CH_W;

  logic [NCH-1:0]  pending;
  logic [NSEL-1:0] pend_ext;
  logic [NCH-1:0]  wr;
  logic            accept;

  // Unused channel slots read as not-pending, so writes to them are accepted
  // and match no channel.
  always_comb begin
    pend_ext          = '0;
    pend_ext[NCH-1:0] = pending;
    cfg_ready         = ~pend_ext[cfg_ch];
    accept            = cfg_valid && cfg_ready;
  end

  // One-hot write strobe per channel.
  always_comb begin
    wr = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      wr[i] = accept && (cfg_ch == CH_W'(i));
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    div_channel #(
      .WIDTH     (WIDTH),
      .RESET_DIV (RESET_DIV)
    ) u_ch (
      .clk_in   (clk_in),
      .rst_n    (rst_n),
      .wr       (wr[g]),
      .wr_div   (cfg_div),
      .wr_pulse (cfg_pulse),
      .en       (ch_en[g]),
      .sync     (sync_in),
      .clk_out  (clk_out[g]),
      .tick     (tick[g]),
      .active   (active[g]),
      .pending  (pending[g])
    );
  end

endmodule

// File: doc/clk_divider_mc.md
Name: clk_divider_mc

Overview:
Multi-channel programmable integer clock divider for the Tiny-PLL clock tree. It generates NCH independent divided clocks from clk_in. Each channel has its own divisor and duty mode. Divisor changes are glitch-free: they are shadowed and applied only at a period boundary. A global sync input re-aligns the phase of all running channels. It is the successor of the single-channel divider and feeds the feedback path and the output clock taps.

Parameters:
NCH, 4, number of output channels (1..16)
WIDTH, 16, divisor/counter width in bits
RESET_DIV, 2, divisor loaded into every channel at reset (must be >= 2)
CH_W, $clog2(NCH) (min 1), width of the channel-select field

Ports:
clk_in  input  1  reference clock; all logic on its rising edge
rst_n  input  1  asynchronous active-low reset
cfg_valid  input  1  configuration write request
cfg_ready  output  1  high when the addressed channel can accept a write
cfg_ch  input  CH_W  target channel of the write
cfg_div  input  WIDTH  new divisor D
cfg_pulse  input  1  new mode: 0 = ~50% duty, 1 = single-cycle pulse
ch_en  input  NCH  per-channel run enable (level)
sync_in  input  1  single-cycle phase-align request
clk_out  output  NCH  divided clocks, registered
tick  output  NCH  one-cycle strobe, high in the cycle each period starts
active  output  NCH  channel is running

Behaviour:
- Reset (async, rst_n=0), for every channel:
  - clk_out=0, tick=0, active=0, counter=0.
  - D_act=RESET_DIV, mode_act=0, pending=0, shadow cleared.
- Period of D cycles, with counter running 0..D-1:
  - clk_out is high while counter < H.
  - H = D>>1 in mode 0, giving floor(D/2) high cycles.
  - H = 1 in mode 1.
  - D >= 2 always, so H >= 1.
- Start condition (idle channel with ch_en=1 at an edge):
  - Next cycle: counter=0, clk_out=1, tick=1, active=1.
  - Latency from ch_en rising to clk_out high: 1 cycle.
- Boundary (counter >= D_act-1):
  - If ch_en=1: counter<=0, clk_out<=1, tick<=1. If pending=1, D_act/mode_act<=shadow and pending<=0.
  - If ch_en=0: clk_out<=0, active<=0, counter<=0, channel goes idle. Pending is still applied at that boundary.
  - The channel therefore always stops only after completing a full period. No runt pulses.
- Non-boundary cycles: counter<=counter+1; clk_out<=(counter+1 < H); tick<=0.
- Config handshake:
  - cfg_ready = !pending[cfg_ch] (combinational on cfg_ch).
  - A write is accepted when cfg_valid && cfg_ready. Shadow <= {clamped div, cfg_pulse}, pending <= 1.
  - cfg_div < 2 is stored as 2.
  - cfg_ch >= NCH: cfg_ready=1, write accepted and discarded.
- Idle channel with pending=1: the shadow is applied on the start edge, so the first period already uses the new value.
- Write accepted in a boundary cycle: pending was 0, so the write is applied at the following boundary, not this one.
- sync_in=1:
  - Every channel with ch_en=1 restarts next cycle (counter=0, clk_out=1, tick=1, active=1) and applies pending.
  - sync takes priority over boundary and normal counting.
  - Disabled or idle channels ignore sync.
- Width rules: counter and D_act are WIDTH bits, and comparisons are unsigned. The counter never exceeds D_act-1 because of the >= compare, so it does not wrap.
- Reset mid-period: outputs drop to 0 immediately (async). Pending writes are lost.

Decomposition:
- Package tpll_div_pkg:
  - MIN_DIV=2.
  - Mode constants MODE_HALF=1'b0, MODE_PULSE=1'b1.
  - Function clamp_div.
- Sub-module div_channel holds one channel:
  - Counter, D_act/mode_act, shadow, pending.
  - Inputs: wr, en, sync.
  - Outputs: clk_out, tick, active, pending.
- clk_divider_mc does the cfg_ch decode, generates cfg_ready, and has a generate loop over NCH.

Test Plan:
- Reset, then ch_en[0]=1 with D=RESET_DIV=2 -> clk_out[0] toggles 1,0,1,0 starting 1 cycle after enable; tick[0] every 2 cycles.
- Write ch1 D=7 mode0 while idle, then enable -> clk_out[1] high 3 cycles, low 4; tick period 7; cfg_ready low only until the start edge.
- Ch2 running D=4; write D=10 mode1 mid-period -> cfg_ready=0 until the boundary. The current period completes as 2 high / 2 low, then 1 high / 9 low.
- Ch0 D=6, ch3 D=9, both running; pulse sync_in -> both show tick, clk_out=1, counter=0 in the same next cycle.
- Drop ch_en[1] at counter=2 of a D=7 period -> the period finishes (low at counters 3..6), then clk_out=0 and active=0. Write cfg_div=0 -> next run uses D=2.
- Assert rst_n=0 mid-period with a write pending -> all outputs 0 immediately; after release D=RESET_DIV and pending=0.
